// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and burst-reader state encoding.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 16;
  localparam int unsigned FIFO_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BURST = 2'b01,
    DRAIN = 2'b10
  } rd_state_e;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read side plus framed output stream of the burst reader.
interface fifo_burst_reader_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
);
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [ADDR_WIDTH-1:0] fifo_depth;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_ren;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_first;
  logic                  out_last;
  logic                  busy;

  // The reader drives the read strobe and the stream.
  modport master (
    input  fifo_data, fifo_depth, fifo_empty, fifo_full, out_ready,
    output fifo_ren, out_data, out_valid, out_first, out_last, busy
  );

  modport slave (
    output fifo_data, fifo_depth, fifo_empty, fifo_full, out_ready,
    input  fifo_ren, out_data, out_valid, out_first, out_last, busy
  );
endinterface

// File: rtl/fifo_out_stage.sv
// One-entry valid/ready output register; payload holds while stalled.
module fifo_out_stage #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_first,
  input  logic                  load_last,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  first,
  output logic                  last
);

  // Load wins over accept so a reload on acceptance keeps full throughput.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      first <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      first <= load_first;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains the FIFO in framed bursts of up to BURST_LEN beats, flushing
// partial bursts after TIMEOUT idle cycles.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_burst_reader_if.master  bus
);

  localparam int unsigned OCC_W    = ADDR_WIDTH + 1;
  localparam int unsigned BEAT_W   = $clog2(BURST_LEN + 1);
  localparam int unsigned TMR_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned FIFO_CAP = 2 ** ADDR_WIDTH;

  localparam logic [OCC_W-1:0]  BURST_OCC  = OCC_W'(BURST_LEN);
  localparam logic [OCC_W-1:0]  FULL_OCC   = OCC_W'(FIFO_CAP);
  localparam logic [BEAT_W-1:0] BEATS_FULL = BEAT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_ONE   = BEAT_W'(1);
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE    = TMR_W'(1);

  rd_state_e         state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic              first_q, first_d;
  logic              busy_q;
  logic              ren_c;
  logic [OCC_W-1:0]  occ_c;

  // Depth wraps to 0 when full, so the full flag restores the true count.
  assign occ_c = bus.fifo_full ? FULL_OCC : {1'b0, bus.fifo_depth};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      beats_q <= '0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      beats_q <= beats_d;
      first_q <= first_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    beats_d = beats_q;
    first_d = first_q;
    ren_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (occ_c >= BURST_OCC) begin
          state_d = BURST;
          beats_d = BEATS_FULL;
          timer_d = '0;
          first_d = 1'b1;
        end else if (occ_c != '0) begin
          if (timer_q == TMR_LAST) begin
            state_d = BURST;
            beats_d = BEAT_W'(occ_c);
            timer_d = '0;
            first_d = 1'b1;
          end else begin
            timer_d = timer_q + TMR_ONE;
          end
        end else begin
          timer_d = '0;
        end
      end
      BURST: begin
        // Beat count was latched at entry; later writes wait for the next burst.
        ren_c = ~bus.fifo_empty & (beats_q != '0) & (~bus.out_valid | bus.out_ready);
        if (ren_c) begin
          beats_d = beats_q - BEAT_ONE;
          first_d = 1'b0;
        end
        if (beats_d == '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.out_valid & bus.out_ready & bus.out_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.fifo_ren = ren_c;
  assign bus.busy     = busy_q;

  fifo_out_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_stage (
    .clk        (clk),
    .reset      (reset),
    .load       (ren_c),
    .load_data  (bus.fifo_data),
    .load_first (first_q),
    .load_last  (beats_q == BEAT_ONE),
    .ready      (bus.out_ready),
    .valid      (bus.out_valid),
    .data       (bus.out_data),
    .first      (bus.out_first),
    .last       (bus.out_last)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader against a word/burst-level model.
module tb_fifo_burst_reader;

  logic clk;
  logic reset;
  logic fifo_clr;
  logic wr_en;
  logic [15:0] wr_data;

  fifo_burst_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

  fifo_burst_reader #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (4),
    .BURST_LEN  (8),
    .TIMEOUT    (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment FIFO: 16 entries, first-word-fall-through.
  logic [15:0] mem [16];
  logic [3:0]  wp, rp;
  logic [4:0]  cnt;
  logic        wr_ok, rd_ok;
  assign wr_ok = wr_en && (cnt != 5'd16);
  assign rd_ok = bus.fifo_ren && (cnt != 5'd0);

  always @(posedge clk or posedge fifo_clr) begin
    if (fifo_clr) begin
      wp  <= 4'd0;
      rp  <= 4'd0;
      cnt <= 5'd0;
    end else begin
      if (wr_ok) begin
        mem[wp] <= wr_data;
        wp      <= wp + 4'd1;
      end
      if (rd_ok) rp <= rp + 4'd1;
      cnt <= cnt + 5'(wr_ok) - 5'(rd_ok);
    end
  end

  assign bus.fifo_data  = mem[rp];
  assign bus.fifo_depth = wp - rp;
  assign bus.fifo_empty = (cnt == 5'd0);
  assign bus.fifo_full  = (cnt == 5'd16);

  // Model and bookkeeping state
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int bursts_q[$];
  int beat_idx = 0;
  int bursts_done = 0;
  bit measuring = 0;
  bit seen_ren = 0;
  int pre_cnt = 0;
  int cur_run = 0;
  int max_run = 0;
  bit rdy_ph = 0;
  logic prev_valid = 0, prev_ready = 0, prev_ren = 0, prev_first = 0, prev_last = 0;
  logic [15:0] prev_data = '0, prev_fdata = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic sample();
    logic [15:0] e;
    if (reset) begin
      prev_valid = 1'b0;
      prev_ren   = 1'b0;
      return;
    end
    if (bus.fifo_ren) cur_run++; else cur_run = 0;
    if (cur_run > max_run) max_run = cur_run;
    if (measuring && !seen_ren) begin
      if (bus.fifo_ren) seen_ren = 1'b1;
      else if (!bus.fifo_empty) pre_cnt++;
    end
    if (bus.fifo_empty) chk("ren_when_empty", 32'(bus.fifo_ren), 32'd0);
    if (prev_valid && !prev_ready) begin
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_data",  32'(bus.out_data),  32'(prev_data));
      chk("stall_first", 32'(bus.out_first), 32'(prev_first));
      chk("stall_last",  32'(bus.out_last),  32'(prev_last));
    end
    if (bus.out_valid && !bus.out_ready) chk("stall_ren", 32'(bus.fifo_ren), 32'd0);
    if (prev_ren) begin
      chk("latency_valid", 32'(bus.out_valid), 32'd1);
      chk("latency_data",  32'(bus.out_data),  32'(prev_fdata));
    end
    if (bus.out_valid) chk("busy_with_valid", 32'(bus.busy), 32'd1);
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0 || bursts_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat: got data %0h, no beat expected", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data",  32'(bus.out_data),  32'(e));
        chk("beat_first", 32'(bus.out_first), 32'(beat_idx == 0));
        chk("beat_last",  32'(bus.out_last),  32'(beat_idx == bursts_q[0] - 1));
        beat_idx++;
        if (beat_idx == bursts_q[0]) begin
          void'(bursts_q.pop_front());
          beat_idx = 0;
          bursts_done++;
        end
      end
    end
    prev_valid = bus.out_valid;
    prev_ready = bus.out_ready;
    prev_data  = bus.out_data;
    prev_first = bus.out_first;
    prev_last  = bus.out_last;
    prev_ren   = bus.fifo_ren;
    prev_fdata = bus.fifo_data;
  endtask

  task automatic tick(input bit wr, input logic [15:0] wd, input bit rdy);
    @(negedge clk);
    wr_en = wr;
    wr_data = wd;
    bus.out_ready = rdy;
    if (wr) exp_q.push_back(wd);
    #1;
    sample();
  endtask

  function automatic bit next_rdy(input bit alt);
    if (alt) begin
      rdy_ph = ~rdy_ph;
      return rdy_ph;
    end
    return 1'b1;
  endfunction

  task automatic wait_done(input int max_cycles, input bit alt, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (bursts_q.size() == 0 && !bus.busy && !bus.out_valid) begin
        done = 1'b1;
        break;
      end
      tick(1'b0, 16'h0, next_rdy(alt));
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: bursts pending %0d, busy %0b", name, bursts_q.size(), bus.busy);
    end
  endtask

  task automatic arm();
    measuring = 1'b1;
    seen_ren  = 1'b0;
    pre_cnt   = 0;
    max_run   = 0;
    cur_run   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    reset = 1'b1;
    fifo_clr = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_first", 32'(bus.out_first), 32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_fifo_ren",  32'(bus.fifo_ren),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    fifo_clr = 1'b0;

    // Full-throughput 8-beat burst
    arm();
    base = bursts_done;
    bursts_q.push_back(8);
    for (int i = 1; i <= 8; i++) tick(1'b1, 16'(i), 1'b1);
    wait_done(60, 1'b0, "t1");
    chk("t1_ren_run", 32'(max_run), 32'd8);
    chk("t1_busy_end", 32'(bus.busy), 32'd0);
    chk("t1_bursts", 32'(bursts_done - base), 32'd1);

    // Alternating back-pressure
    arm();
    bursts_q.push_back(8);
    for (int i = 0; i < 8; i++) tick(1'b1, 16'h0030 + 16'(i), next_rdy(1'b1));
    wait_done(80, 1'b1, "t3");
    chk("t3_all_delivered", 32'(exp_q.size()), 32'd0);

    // Threshold reached at timer=10 wins over timeout
    arm();
    bursts_q.push_back(8);
    for (int i = 0; i < 5; i++) tick(1'b1, 16'h0050 + 16'(i), 1'b1);
    repeat (3) tick(1'b0, 16'h0, 1'b1);
    for (int i = 5; i < 8; i++) tick(1'b1, 16'h0050 + 16'(i), 1'b1);
    wait_done(60, 1'b0, "t5");
    chk("t5_wait_before_read", 32'(pre_cnt), 32'd11);

    // Partial burst flushed by timeout
    arm();
    bursts_q.push_back(3);
    for (int i = 1; i <= 3; i++) tick(1'b1, 16'h00A0 + 16'(i), 1'b1);
    wait_done(80, 1'b0, "t2");
    chk("t2_wait_before_read", 32'(pre_cnt), 32'd16);
    chk("t2_fifo_empty", 32'(bus.fifo_empty), 32'd1);

    // Full FIFO (depth wraps to 0): two back-to-back 8-beat bursts
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) tick(1'b1, 16'h0040 + 16'(i), 1'b1);
    chk("t4_idle_in_reset", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    arm();
    base = bursts_done;
    bursts_q.push_back(8);
    bursts_q.push_back(8);
    wait_done(100, 1'b0, "t4");
    chk("t4_bursts", 32'(bursts_done - base), 32'd2);
    chk("t4_ren_run", 32'(max_run), 32'd8);

    // Reset in the middle of a burst
    bursts_q.push_back(8);
    for (int i = 0; i < 8; i++) tick(1'b1, 16'h0060 + 16'(i), 1'b1);
    for (int i = 0; i < 40 && beat_idx < 3; i++) tick(1'b0, 16'h0, 1'b1);
    chk("t6_mid_burst_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    fifo_clr = 1'b1;
    #1;
    chk("t6_async_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_async_busy",  32'(bus.busy),      32'd0);
    chk("t6_async_ren",   32'(bus.fifo_ren),  32'd0);
    exp_q.delete();
    bursts_q.delete();
    beat_idx = 0;
    prev_valid = 1'b0;
    prev_ren = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    fifo_clr = 1'b0;

    // Fresh single-word partial burst after reset
    arm();
    bursts_q.push_back(1);
    tick(1'b1, 16'h0077, 1'b1);
    wait_done(60, 1'b0, "t6");
    chk("t6_wait_before_read", 32'(pre_cnt), 32'd16);
    chk("t6_busy_end", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
